ps2_kbd_rx: RTL and testbench

//  Host-side PS/2 keyboard receiver in the core. Receives the 11-bit frames driven on ps2_kbd_clk/ps2_kbd_data
//  by the I/O controller bridge. Checks framing/parity, folds E0/F0 prefixes into key events, and buffers the

---
 rtl/ps2_kbd_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// Host-side PS/2 keyboard receiver. Receives the 11-bit frames (start, eight
// data bits LSB first, odd parity, stop) on ps2_clk/ps2_data. It checks the
// framing and the parity, and folds the E0 (extended) and F0 (break) prefixes
// into key events. The events go into a show-ahead FIFO that the keyboard
// matrix logic reads.
//
// Ports
//   clk_sys      in   system clock, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   ps2_clk      in   PS/2 clock, asynchronous, idle high
//   ps2_data     in   PS/2 data, asynchronous, idle high
//   rx_byte      out  last correctly received raw byte
//   rx_strobe    out  1-cycle pulse when rx_byte updates
//   key_code     out  head-of-FIFO scancode (0 when FIFO empty)
//   key_ext      out  head event was E0-prefixed
//   key_release  out  head event was F0-prefixed
//   key_valid    out  FIFO not empty
//   key_rd       in   pop head event (ignored when empty)
//   parity_err   out  1-cycle pulse, frame dropped for bad parity
//   frame_err    out  1-cycle pulse, frame dropped for bad stop or timeout
//   overflow     out  sticky, an event was lost because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 4096,
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_rd,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW   = $clog2(FILTER + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_BITS;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]           clkSync_q, dataSync_q;
  logic                 clkS, dataS;
  logic                 filtClk_q, filtClk_d;
  logic [FCW-1:0]       filtCnt_q, filtCnt_d;
  logic                 fall;

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bitCnt_q, bitCnt_d;
  logic                 parBit_q, parBit_d;
  logic [TCW-1:0]       toCnt_q, toCnt_d;
  logic [7:0]           rxByte_q, rxByte_d;
  logic                 strobe_q, strobe_d;
  logic                 parErr_q, parErr_d;
  logic                 frmErr_q, frmErr_d;

  logic                 ext_q, rel_q, overflow_q;
  logic [FIFO_BITS:0]   wrPtr_q, rdPtr_q;
  logic [9:0]           mem [DEPTH];
  logic [9:0]           head;
  logic                 isPrefix, push, pop, empty, full, doWrite;

  // Two-flop synchronisers; they reset to the idle-high bus level so that
  // no edge appears when reset is released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  assign clkS  = clkSync_q[1];
  assign dataS = dataSync_q[1];

  // The filtered clock follows the synchronised clock only after that clock
  // has held a different level for FILTER consecutive cycles. A fall is
  // flagged in the same cycle that the filtered level is updated, so the data
  // bit is sampled at that moment.
  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    fall      = 1'b0;
    if (clkS != filtClk_q) begin
      if (filtCnt_q == FCW'(FILTER - 1)) begin
        filtClk_d = clkS;
        fall      = filtClk_q;
      end else begin
        filtCnt_d = filtCnt_q + 1'b1;
      end
    end
  end

  // The frame FSM moves only on filtered falls. The watchdog counts idle
  // cycles between falls while a frame is in progress. When it reaches
  // TIMEOUT, the partial frame is aborted. The prefix flags live in the
  // decoder, so the abort leaves them untouched.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    parBit_d = parBit_q;
    rxByte_d = rxByte_q;
    strobe_d = 1'b0;
    parErr_d = 1'b0;
    frmErr_d = 1'b0;

    if (state_q == IDLE || fall) begin
      toCnt_d = '0;
    end else begin
      toCnt_d = toCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fall && !dataS) begin
          state_d  = DATA;
          bitCnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {dataS, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parBit_d = dataS;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!dataS) begin
            frmErr_d = 1'b1;
          end else if (^{shift_q, parBit_q}) begin
            strobe_d = 1'b1;
            rxByte_d = shift_q;
          end else begin
            parErr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall && toCnt_q == TCW'(TIMEOUT - 1)) begin
      state_d  = IDLE;
      frmErr_d = 1'b1;
      toCnt_d  = '0;
    end
  end

  // Receiver state, filter and registered output pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      parBit_q  <= 1'b0;
      toCnt_q   <= '0;
      rxByte_q  <= '0;
      strobe_q  <= 1'b0;
      parErr_q  <= 1'b0;
      frmErr_q  <= 1'b0;
    end else begin
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      parBit_q  <= parBit_d;
      toCnt_q   <= toCnt_d;
      rxByte_q  <= rxByte_d;
      strobe_q  <= strobe_d;
      parErr_q  <= parErr_d;
      frmErr_q  <= frmErr_d;
    end
  end

  // The decoder and FIFO act on the registered strobe. A prefix byte sets
  // its flag. Any other byte is pushed together with the flags, and the
  // flags are then cleared, even when the push is lost to a full FIFO.
  // The pointers carry one extra bit so that full and empty can be told
  // apart.
  assign isPrefix = (rxByte_q == 8'hE0) || (rxByte_q == 8'hF0);
  assign push     = strobe_q && !isPrefix;
  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[FIFO_BITS] != rdPtr_q[FIFO_BITS]) &&
                    (wrPtr_q[FIFO_BITS-1:0] == rdPtr_q[FIFO_BITS-1:0]);
  assign pop      = key_rd && !empty;
  assign doWrite  = push && (!full || pop);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      if (strobe_q) begin
        if (rxByte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (rxByte_q == 8'hF0) begin
          rel_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          rel_q <= 1'b0;
        end
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (doWrite) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  // Event storage needs no reset because the outputs are masked while the
  // FIFO is empty. When the FIFO is full and a pop happens in the same
  // cycle, the write lands in the slot being popped.
  always_ff @(posedge clk_sys) begin
    if (doWrite) begin
      mem[wrPtr_q[FIFO_BITS-1:0]] <= {ext_q, rel_q, rxByte_q};
    end
  end

  assign head        = mem[rdPtr_q[FIFO_BITS-1:0]];
  assign key_valid   = !empty;
  assign key_code    = key_valid ? head[7:0] : 8'h00;
  assign key_release = key_valid & head[8];
  assign key_ext     = key_valid & head[9];
  assign rx_byte     = rxByte_q;
  assign rx_strobe   = strobe_q;
  assign parity_err  = parErr_q;
  assign frame_err   = frmErr_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Self-checking bench for ps2_kbd_rx. A table of single-frame vectors covers
// decoding, prefixes, error frames and clock glitches. Hand-written sequences
// cover the timeout, FIFO overflow and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int FILTER    = 4;
  localparam int TIMEOUT   = 4096;
  localparam int FIFO_BITS = 3;
  localparam int NOGLITCH  = 99;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_rd = 1'b0;
  logic [7:0] rx_byte, key_code;
  logic       rx_strobe, key_ext, key_release, key_valid;
  logic       parity_err, frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int strobeCyc = 0;
  int parCyc = 0;
  int frmCyc = 0;

  ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_valid(key_valid), .key_rd(key_rd),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Count the high cycles of each pulse output. The counts are taken on the
  // falling edge so that they stay clear of the active clock edge. A correct
  // pulse adds exactly one count.
  always @(negedge clk_sys) begin
    if (rx_strobe)  strobeCyc++;
    if (parity_err) parCyc++;
    if (frame_err)  frmCyc++;
  end

  typedef struct {
    logic [7:0] data;
    bit         flipPar;
    bit         stopBit;
    int         glitchAt;
    int         expStrobe;
    int         expPar;
    int         expFrm;
    bit         expEvent;
    logic [7:0] expCode;
    bit         expExt;
    bit         expRel;
  } vec_t;

  function automatic vec_t mkVec(logic [7:0] d, bit fp, bit sb, int g, int es, int ep,
                                 int ef, bit ev, logic [7:0] c, bit x, bit r);
    vec_t v;
    v.data = d; v.flipPar = fp; v.stopBit = sb; v.glitchAt = g;
    v.expStrobe = es; v.expPar = ep; v.expFrm = ef;
    v.expEvent = ev; v.expCode = c; v.expExt = x; v.expRel = r;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2Bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic glitchLow();
    ps2_clk = 1'b0;
    repeat (FILTER - 1) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  // Send one frame. glitchAt=0 places a glitch before the start bit, while
  // the line is idle. glitchAt=k places a glitch after the k-th bit, with the
  // start bit counted as bit 1.
  task automatic applyStimulus(input logic [7:0] d, input bit flip, input bit stopB, input int glitchAt);
    logic [10:0] bits;
    bits = {stopB, (~^d) ^ flip, d, 1'b0};
    if (glitchAt == 0) glitchLow();
    for (int i = 0; i < 11; i++) begin
      ps2Bit(bits[i]);
      if (glitchAt == i + 1) glitchLow();
    end
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic popOne();
    key_rd = 1'b1;
    @(negedge clk_sys);
    key_rd = 1'b0;
    @(negedge clk_sys);
  endtask

  vec_t vecs[12];

  initial begin
    int s0, p0, f0;

    vecs[0]  = mkVec(8'h1C, 0, 1, NOGLITCH, 1, 0, 0, 1, 8'h1C, 0, 0);
    vecs[1]  = mkVec(8'hE0, 0, 1, NOGLITCH, 1, 0, 0, 0, 8'h00, 0, 0);
    vecs[2]  = mkVec(8'hF0, 0, 1, NOGLITCH, 1, 0, 0, 0, 8'h00, 0, 0);
    vecs[3]  = mkVec(8'h75, 0, 1, NOGLITCH, 1, 0, 0, 1, 8'h75, 1, 1);
    vecs[4]  = mkVec(8'h75, 0, 1, NOGLITCH, 1, 0, 0, 1, 8'h75, 0, 0);
    vecs[5]  = mkVec(8'h1C, 1, 1, NOGLITCH, 0, 1, 0, 0, 8'h00, 0, 0);
    vecs[6]  = mkVec(8'h1C, 0, 0, NOGLITCH, 0, 0, 1, 0, 8'h00, 0, 0);
    vecs[7]  = mkVec(8'hF0, 0, 1, NOGLITCH, 1, 0, 0, 0, 8'h00, 0, 0);
    vecs[8]  = mkVec(8'h12, 0, 1, NOGLITCH, 1, 0, 0, 1, 8'h12, 0, 1);
    vecs[9]  = mkVec(8'hE0, 0, 1, 0,        1, 0, 0, 0, 8'h00, 0, 0);
    vecs[10] = mkVec(8'h6B, 0, 1, 4,        1, 0, 0, 1, 8'h6B, 1, 0);
    vecs[11] = mkVec(8'hA5, 0, 1, 1,        1, 0, 0, 1, 8'hA5, 0, 0);

    // Check the reset state while reset is held.
    repeat (3) @(negedge clk_sys);
    checkOutput("reset rx_byte", {24'd0, rx_byte}, 32'h0);
    checkOutput("reset rx_strobe", {31'd0, rx_strobe}, 32'h0);
    checkOutput("reset key_valid", {31'd0, key_valid}, 32'h0);
    checkOutput("reset key_code", {24'd0, key_code}, 32'h0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'h0);
    checkOutput("reset errs", {30'd0, parity_err, frame_err}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    // Apply the table-driven frames.
    for (int i = 0; i < 12; i++) begin
      s0 = strobeCyc; p0 = parCyc; f0 = frmCyc;
      applyStimulus(vecs[i].data, vecs[i].flipPar, vecs[i].stopBit, vecs[i].glitchAt);
      checkOutput($sformatf("v%0d strobe", i), strobeCyc - s0, vecs[i].expStrobe);
      checkOutput($sformatf("v%0d parity_err", i), parCyc - p0, vecs[i].expPar);
      checkOutput($sformatf("v%0d frame_err", i), frmCyc - f0, vecs[i].expFrm);
      if (vecs[i].expStrobe != 0)
        checkOutput($sformatf("v%0d rx_byte", i), {24'd0, rx_byte}, {24'd0, vecs[i].data});
      checkOutput($sformatf("v%0d key_valid", i), {31'd0, key_valid}, {31'd0, vecs[i].expEvent});
      if (vecs[i].expEvent) begin
        checkOutput($sformatf("v%0d key_code", i), {24'd0, key_code}, {24'd0, vecs[i].expCode});
        checkOutput($sformatf("v%0d key_ext", i), {31'd0, key_ext}, {31'd0, vecs[i].expExt});
        checkOutput($sformatf("v%0d key_release", i), {31'd0, key_release}, {31'd0, vecs[i].expRel});
        popOne();
        checkOutput($sformatf("v%0d valid after pop", i), {31'd0, key_valid}, 32'h0);
      end else begin
        checkOutput($sformatf("v%0d key_code idle", i), {24'd0, key_code}, 32'h0);
      end
    end

    // Pop on an empty FIFO has no effect.
    popOne();
    checkOutput("empty pop valid", {31'd0, key_valid}, 32'h0);

    // Stop clocking after four data bits. The frame times out, and the next
    // frame still decodes.
    s0 = strobeCyc; f0 = frmCyc;
    ps2Bit(1'b0);
    for (int b = 0; b < 4; b++) ps2Bit(1'b1);
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    checkOutput("timeout frame_err", frmCyc - f0, 1);
    checkOutput("timeout no strobe", strobeCyc - s0, 0);
    checkOutput("timeout no event", {31'd0, key_valid}, 32'h0);
    applyStimulus(8'h2A, 0, 1, NOGLITCH);
    checkOutput("post-timeout valid", {31'd0, key_valid}, 32'h1);
    checkOutput("post-timeout code", {24'd0, key_code}, 32'h2A);
    checkOutput("post-timeout ext/rel", {30'd0, key_ext, key_release}, 32'h0);
    popOne();

    // Fill the FIFO past its depth without reading.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(8'(k), 0, 1, NOGLITCH);
      if (k == 8) checkOutput("overflow before 9th", {31'd0, overflow}, 32'h0);
    end
    checkOutput("overflow after 9th", {31'd0, overflow}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("fifo valid %0d", k), {31'd0, key_valid}, 32'h1);
      checkOutput($sformatf("fifo code %0d", k), {24'd0, key_code}, k);
      popOne();
    end
    checkOutput("fifo drained", {31'd0, key_valid}, 32'h0);
    checkOutput("overflow sticky", {31'd0, overflow}, 32'h1);

    // Assert reset in the middle of a frame while one event is buffered.
    applyStimulus(8'h33, 0, 1, NOGLITCH);
    checkOutput("pre-reset valid", {31'd0, key_valid}, 32'h1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("midreset rx_byte", {24'd0, rx_byte}, 32'h0);
    checkOutput("midreset key_valid", {31'd0, key_valid}, 32'h0);
    checkOutput("midreset key_code", {24'd0, key_code}, 32'h0);
    checkOutput("midreset overflow", {31'd0, overflow}, 32'h0);
    checkOutput("midreset pulses", {29'd0, rx_strobe, parity_err, frame_err}, 32'h0);
    reset_n = 1'b1;
    f0 = frmCyc; p0 = parCyc;
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    checkOutput("midreset no frame_err", frmCyc - f0, 0);
    checkOutput("midreset no parity_err", parCyc - p0, 0);
    applyStimulus(8'h4B, 0, 1, NOGLITCH);
    checkOutput("post-reset valid", {31'd0, key_valid}, 32'h1);
    checkOutput("post-reset code", {24'd0, key_code}, 32'h4B);
    checkOutput("post-reset rx_byte", {24'd0, rx_byte}, 32'h4B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
